// File: rtl/factorial_core.sv
// Iterative n! mod 2^DATA_W engine with a joined input and an eager output fork.
// Optional FACTORIAL_SATURATE_EN: overflowed results present all ones.
module factorial_core #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] n,
    input  logic              n_valid,
    output logic              n_ready,
    input  logic              start_valid,
    output logic              start_ready,
    output logic [DATA_W-1:0] out0,
    output logic              out0_ovf,
    output logic              out0_valid,
    input  logic              out0_ready,
    output logic              end_valid,
    input  logic              end_ready
);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [DATA_W-1:0]   r_acc;
    logic [DATA_W-1:0]   r_i;
    logic                r_ovf;
    logic                r_res_sent;
    logic                r_end_sent;
    logic [2*DATA_W-1:0] w_prod;
    logic [DATA_W-1:0]   w_res;
    logic                w_accept;
    logic                w_last;
    logic                w_res_hs;
    logic                w_end_hs;
    logic                w_all_sent;

    assign w_prod = {{DATA_W{1'b0}}, r_acc} * {{DATA_W{1'b0}}, r_i};
    assign w_last = (r_i <= DATA_W'(1));

`ifdef FACTORIAL_SATURATE_EN
    assign w_res = r_ovf ? {DATA_W{1'b1}} : r_acc;
`else
    assign w_res = r_acc;
`endif

    assign out0     = (r_state == DONE) ? w_res : '0;
    assign out0_ovf = (r_state == DONE) & r_ovf;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state, input join and output fork handshakes
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        n_ready     = 1'b0;
        start_ready = 1'b0;
        out0_valid  = 1'b0;
        end_valid   = 1'b0;
        w_res_hs    = 1'b0;
        w_end_hs    = 1'b0;
        w_all_sent  = 1'b0;
        unique case (r_state)
            IDLE: begin
                w_accept    = n_valid & start_valid;
                n_ready     = w_accept;
                start_ready = w_accept;
                if (w_accept) begin
                    w_state_nxt = CALC;
                end
            end
            CALC: begin
                if (w_last) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                out0_valid = ~r_res_sent;
                end_valid  = ~r_end_sent;
                w_res_hs   = out0_valid & out0_ready;
                w_end_hs   = end_valid & end_ready;
                w_all_sent = (r_res_sent | w_res_hs) & (r_end_sent | w_end_hs);
                if (w_all_sent) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Accumulator, down-counter, sticky overflow and delivery flags
    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc      <= DATA_W'(1);
            r_i        <= '0;
            r_ovf      <= 1'b0;
            r_res_sent <= 1'b0;
            r_end_sent <= 1'b0;
        end else begin
            if (w_accept) begin
                r_acc <= DATA_W'(1);
                r_i   <= n;
                r_ovf <= 1'b0;
            end else if ((r_state == CALC) && !w_last) begin
                r_acc <= w_prod[DATA_W-1:0];
                r_ovf <= r_ovf | (w_prod[2*DATA_W-1:DATA_W] != '0);
                r_i   <= r_i - DATA_W'(1);
            end
            if (r_state == DONE) begin
                if (w_all_sent) begin
                    r_res_sent <= 1'b0;
                    r_end_sent <= 1'b0;
                end else begin
                    r_res_sent <= r_res_sent | w_res_hs;
                    r_end_sent <= r_end_sent | w_end_hs;
                end
            end
        end
    end

endmodule

// File: tb/tb_factorial_core.sv
// Bench for factorial_core: directed scenarios plus randomized traffic
// checked every cycle against a transaction-level factorial model.
module tb_factorial_core;

    localparam int W = 8;
    localparam longint unsigned MOD = 64'd1 << W;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [W-1:0] n_i = '0;
    logic         nv = 1'b0;
    logic         sv = 1'b0;
    logic         ordy = 1'b0;
    logic         erdy = 1'b0;
    logic         n_ready;
    logic         start_ready;
    logic [W-1:0] out0;
    logic         out0_ovf;
    logic         out0_valid;
    logic         end_valid;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    int           m_ph = 0;
    int           m_left = 0;
    logic [W-1:0] m_res = '0;
    bit           m_ovf = 1'b0;
    bit           m_rs = 1'b0;
    bit           m_es = 1'b0;

    factorial_core #(.DATA_W(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .n           (n_i),
        .n_valid     (nv),
        .n_ready     (n_ready),
        .start_valid (sv),
        .start_ready (start_ready),
        .out0        (out0),
        .out0_ovf    (out0_ovf),
        .out0_valid  (out0_valid),
        .out0_ready  (ordy),
        .end_valid   (end_valid),
        .end_ready   (erdy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Mathematical n!: modular value, and whether the true value reaches 2^W
    function automatic void fact(input int nn, output logic [W-1:0] r,
                                 output bit ovf);
        longint unsigned m;
        longint unsigned ex;
        m = 1;
        ex = 1;
        ovf = 1'b0;
        for (int k = 2; k <= nn; k++) begin
            m = (m * longint'(k)) % MOD;
            if (!ovf) begin
                ex = ex * longint'(k);
                if (ex >= MOD) ovf = 1'b1;
            end
        end
`ifdef FACTORIAL_SATURATE_EN
        r = ovf ? {W{1'b1}} : W'(m);
`else
        r = W'(m);
`endif
    endfunction

    // Per-cycle compare against the model, then advance the model
    always @(negedge clk) begin
        bit exp_nr;
        if (chk_en) begin
            exp_nr = (m_ph == 0) && nv && sv;
            chk("n_ready", n_ready, exp_nr);
            chk("start_ready", start_ready, exp_nr);
            chk("out0_valid", out0_valid, (m_ph == 2) && !m_rs);
            chk("end_valid", end_valid, (m_ph == 2) && !m_es);
            if ((m_ph == 2) && !m_rs) begin
                chk("out0", out0, m_res);
                chk("out0_ovf", out0_ovf, m_ovf);
            end
        end
        if (rst) begin
            m_ph = 0;
            m_rs = 1'b0;
            m_es = 1'b0;
        end else begin
            case (m_ph)
                0: if (nv && sv) begin
                    fact(int'(n_i), m_res, m_ovf);
                    m_left = (n_i > 1) ? int'(n_i) : 1;
                    m_ph = 1;
                end
                1: begin
                    m_left--;
                    if (m_left == 0) m_ph = 2;
                end
                default: begin
                    if (ordy) m_rs = 1'b1;
                    if (erdy) m_es = 1'b1;
                    if (m_rs && m_es) begin
                        m_ph = 0;
                        m_rs = 1'b0;
                        m_es = 1'b0;
                    end
                end
            endcase
        end
    end

    task automatic run_op(input int nn, input logic [W-1:0] ev,
                          input bit eo, input int elat);
        int lat;
        bit got;
        n_i = W'(nn);
        nv = 1'b1;
        sv = 1'b1;
        ordy = 1'b1;
        erdy = 1'b1;
        #1;
        chk("join_ready", n_ready, 1'b1);
        @(posedge clk);
        #1;
        nv = 1'b0;
        sv = 1'b0;
        lat = 0;
        got = 1'b0;
        while (!got && lat < 600) begin
            @(posedge clk);
            #1;
            lat++;
            if (out0_valid) got = 1'b1;
        end
        chk("latency", lat, elat);
        chk("res", out0, ev);
        chk("res_ovf", out0_ovf, eo);
        chk("end_with_res", end_valid, 1'b1);
        @(posedge clk);
        #1;
        chk("idle_after", {out0_valid, end_valid}, 2'b00);
    endtask

    initial begin
        logic [W-1:0] r;
        bit o;
        bit got;
        int guard;

        fact(5, r, o);
        chk("model_5", {o, r}, {1'b0, 8'd120});
        fact(0, r, o);
        chk("model_0", {o, r}, {1'b0, 8'd1});
        fact(4, r, o);
        chk("model_4", {o, r}, {1'b0, 8'd24});
        fact(6, r, o);
`ifdef FACTORIAL_SATURATE_EN
        chk("model_6", {o, r}, {1'b1, 8'd255});
`else
        chk("model_6", {o, r}, {1'b1, 8'd208});
`endif

        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_out0", out0, 0);
        chk("rst_valids", {out0_valid, end_valid, out0_ovf}, 3'b000);
        chk("rst_ready", {n_ready, start_ready}, 2'b00);
        chk_en = 1'b1;

        run_op(5, 8'd120, 1'b0, 5);
        run_op(0, 8'd1, 1'b0, 1);
        run_op(1, 8'd1, 1'b0, 1);
`ifdef FACTORIAL_SATURATE_EN
        run_op(6, 8'd255, 1'b1, 6);
`else
        run_op(6, 8'd208, 1'b1, 6);
`endif

        n_i = 8'd2;
        nv = 1'b1;
        sv = 1'b0;
        repeat (4) begin
            @(posedge clk);
            #1;
            chk("join_wait", n_ready, 1'b0);
        end
        run_op(2, 8'd2, 1'b0, 2);

        n_i = 8'd3;
        nv = 1'b1;
        sv = 1'b1;
        ordy = 1'b0;
        erdy = 1'b1;
        @(posedge clk);
        #1;
        nv = 1'b0;
        sv = 1'b0;
        got = 1'b0;
        guard = 0;
        while (!got && guard < 600) begin
            @(posedge clk);
            #1;
            guard++;
            if (out0_valid) got = 1'b1;
        end
        chk("bp_seen", got, 1'b1);
        repeat (3) begin
            @(posedge clk);
            #1;
            chk("bp_end_gone", end_valid, 1'b0);
            chk("bp_res_held", {out0_valid, out0}, {1'b1, 8'd6});
        end
        ordy = 1'b1;
        @(posedge clk);
        #1;
        chk("bp_done", out0_valid, 1'b0);

        n_i = 8'd7;
        nv = 1'b1;
        sv = 1'b1;
        @(posedge clk);
        #1;
        nv = 1'b0;
        sv = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("mid_rst_valids", {out0_valid, end_valid}, 2'b00);
        run_op(4, 8'd24, 1'b0, 4);

        repeat (4000) begin
            @(posedge clk);
            #1;
            nv = ($urandom % 4) != 0;
            sv = ($urandom % 4) != 0;
            n_i = (($urandom % 8) == 0) ? W'($urandom_range(0, 255))
                                        : W'($urandom_range(0, 10));
            ordy = $urandom % 2;
            erdy = $urandom % 2;
            rst = ($urandom % 300) == 0;
        end
        rst = 1'b0;
        nv = 1'b0;
        sv = 1'b0;
        ordy = 1'b1;
        erdy = 1'b1;
        repeat (300) @(posedge clk);
        #1;
        chk("drained", {out0_valid, end_valid}, 2'b00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
